// File: rtl/spm_mc_pkg.sv
// spm_mc_pkg: lane state type and bit-counter sizing shared by the multiplier lanes
package spm_mc_pkg;
  typedef enum logic {IDLE, RUN} lane_state_t;
  function automatic int cnt_w(input int width);
    return $clog2(2 * width);
  endfunction
endpackage

// File: rtl/spm_lane.sv
// spm_lane: one serial-parallel multiplier lane; ports clk, rst, start, tc, x (parallel), y (serial LSB first) -> p (serial LSB first), p_valid, busy, done
module spm_lane
  import spm_mc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             tc,
  input  logic [WIDTH-1:0] x,
  input  logic             y,
  output logic             p,
  output logic             p_valid,
  output logic             busy,
  output logic             done
);
  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(2 * WIDTH - 1);
  localparam logic [CW-1:0] YLAST = CW'(WIDTH - 1);
  lane_state_t state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] xr, xs;
  logic tcr, ylast, accept, ts, yb;
  // two guard bits keep the signed running sum exact for either operand mode
  logic [WIDTH+1:0] acc, xe, sum;
  always_comb begin
    accept = start && (!busy || done);
    xs = accept ? x : xr;
    ts = accept ? tc : tcr;
    xe = {{2{ts & xs[WIDTH-1]}}, xs};
    // past the last real y bit the multiplier is extended by its sign (or 0)
    yb = (accept || cnt < YLAST) ? y : tcr & ylast;
    sum = (accept ? '0 : acc) + (yb ? xe : '0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      xr <= '0;
      tcr <= 1'b0;
      ylast <= 1'b0;
      acc <= '0;
      p <= 1'b0;
      p_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else if (accept || (state == RUN && !done)) begin
      state <= RUN;
      cnt <= accept ? '0 : cnt + 1'b1;
      if (accept) begin
        xr <= x;
        tcr <= tc;
      end
      ylast <= yb;
      acc <= {sum[WIDTH+1], sum[WIDTH+1:1]};
      p <= sum[0];
      p_valid <= 1'b1;
      busy <= 1'b1;
      done <= accept ? 1'b0 : (cnt + 1'b1 == LAST);
    end else begin
      state <= IDLE;
      cnt <= '0;
      acc <= '0;
      p <= 1'b0;
      p_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end
  end
endmodule

// File: rtl/spm_mc.sv
// spm_mc: CHANNELS independent serial-parallel multiplier lanes; per-lane start, tc, x[i*WIDTH+:WIDTH], y -> p, p_valid, busy, done
module spm_mc #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       start,
  input  logic [CHANNELS-1:0]       tc,
  input  logic [CHANNELS*WIDTH-1:0] x,
  input  logic [CHANNELS-1:0]       y,
  output logic [CHANNELS-1:0]       p,
  output logic [CHANNELS-1:0]       p_valid,
  output logic [CHANNELS-1:0]       busy,
  output logic [CHANNELS-1:0]       done
);
  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    spm_lane #(.WIDTH(WIDTH)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .start  (start[i]),
      .tc     (tc[i]),
      .x      (x[i*WIDTH +: WIDTH]),
      .y      (y[i]),
      .p      (p[i]),
      .p_valid(p_valid[i]),
      .busy   (busy[i]),
      .done   (done[i])
    );
  end
endmodule

// File: tb/tb_spm_mc.sv
// tb_spm_mc: randomized self-checking bench for spm_mc against an arithmetic product model
module tb_spm_mc;
  localparam int W = 32, CH = 2;
  logic clk = 1'b0, rst;
  logic [CH-1:0] start, tc, y, p, p_valid, busy, done;
  logic [CH*W-1:0] x;
  int checks = 0, errors = 0, cyc = 0, bad = 0;
  logic [W-1:0] ysrc [CH];
  int ypos [CH], nbits [CH], pv_run [CH];
  logic [2*W-1:0] bits [CH];
  logic [2*W-1:0] res_q [CH][$];
  int rcyc_q [CH][$];

  spm_mc #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clk(clk), .rst(rst), .start(start), .tc(tc), .x(x), .y(y),
    .p(p), .p_valid(p_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic [2*W-1:0] ae, be;
    ae = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    be = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    return ae * be;
  endfunction

  // advance one cycle, stream y bits, randomize don't-care inputs, reassemble serial products
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    start = '0;
    for (int l = 0; l < CH; l++) begin
      x[l*W +: W] = $urandom;
      tc[l] = 1'($urandom_range(0, 1));
      y[l] = ypos[l] < W ? ysrc[l][ypos[l]] : 1'($urandom_range(0, 1));
      ypos[l]++;
      if (p_valid[l]) begin
        bits[l][nbits[l]] = p[l];
        nbits[l]++;
        pv_run[l]++;
        if (nbits[l] == 2 * W) begin
          res_q[l].push_back(bits[l]);
          rcyc_q[l].push_back(cyc);
          nbits[l] = 0;
          if (!done[l]) bad++;
        end else if (done[l]) bad++;
      end else begin
        if (p[l] || done[l]) bad++;
        nbits[l] = 0;
        pv_run[l] = 0;
      end
    end
  endtask

  task automatic launch(input int l, input logic [W-1:0] xv, input logic [W-1:0] yv, input logic t);
    x[l*W +: W] = xv;
    tc[l] = t;
    start[l] = 1'b1;
    ysrc[l] = yv;
    y[l] = yv[0];
    ypos[l] = 1;
  endtask

  task automatic collect(input int l, output logic [2*W-1:0] r, output int rc);
    int k;
    k = 0;
    while (res_q[l].size() == 0 && k < 300) begin
      step();
      k++;
    end
    if (res_q[l].size() == 0) begin
      r = 'x;
      rc = -1;
    end else begin
      r = res_q[l].pop_front();
      rc = rcyc_q[l].pop_front();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    start = '1;
    checks++;
    if ({p, p_valid, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %b want 0", {p, p_valid, busy, done});
    end
    step();
    rst = 1'b0;
    checks++;
    if ({busy, p_valid} !== '0) begin
      errors++;
      $display("FAIL reset_start_ignored busy/p_valid got %b want 0", {busy, p_valid});
    end
  endtask

  task automatic test_basic();
    int t, rc;
    logic [2*W-1:0] r;
    launch(0, 3, 5, 1'b0);
    t = cyc;
    step();
    checks++;
    if (busy[0] !== 1'b1 || p_valid[0] !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy got busy=%b p_valid=%b want 1 1", busy[0], p_valid[0]);
    end
    collect(0, r, rc);
    checks++;
    if (r !== 64'd15) begin
      errors++;
      $display("FAIL basic_product got %h want %h", r, 64'd15);
    end
    checks++;
    if (rc !== t + 64) begin
      errors++;
      $display("FAIL basic_done_cycle got %0d want %0d", rc, t + 64);
    end
  endtask

  task automatic test_ones();
    int rc;
    logic [2*W-1:0] r, want;
    for (int s = 1; s >= 0; s--) begin
      repeat (2) step();
      launch(0, '1, '1, 1'(s));
      want = s ? 64'h0000000000000001 : 64'hFFFFFFFE00000001;
      collect(0, r, rc);
      checks++;
      if (r !== want) begin
        errors++;
        $display("FAIL ones_tc%0d got %h want %h", s, r, want);
      end
    end
  endtask

  task automatic test_two_lanes();
    int t, rc0, rc1;
    logic [2*W-1:0] r0, r1;
    repeat (2) step();
    launch(0, 7, 9, 1'b0);
    t = cyc;
    repeat (5) step();
    launch(1, 32'hFFFFFFFE, 3, 1'b1);
    collect(0, r0, rc0);
    collect(1, r1, rc1);
    checks++;
    if (r0 !== 64'd63) begin
      errors++;
      $display("FAIL two_lanes_l0 got %h want %h", r0, 64'd63);
    end
    checks++;
    if (r1 !== 64'hFFFFFFFFFFFFFFFA) begin
      errors++;
      $display("FAIL two_lanes_l1 got %h want %h", r1, 64'hFFFFFFFFFFFFFFFA);
    end
    checks++;
    if (rc0 !== t + 64 || rc1 - rc0 !== 5) begin
      errors++;
      $display("FAIL two_lanes_done got %0d/%0d want %0d/%0d", rc0, rc1, t + 64, t + 69);
    end
  endtask

  task automatic test_ignore();
    int t, rc;
    logic [W-1:0] xv, yv;
    logic tv;
    logic [2*W-1:0] r;
    repeat (2) step();
    xv = $urandom;
    yv = $urandom;
    tv = 1'($urandom_range(0, 1));
    launch(0, xv, yv, tv);
    t = cyc;
    repeat (10) step();
    start[0] = 1'b1;
    x[W-1:0] = ~xv;
    collect(0, r, rc);
    checks++;
    if (r !== model(xv, yv, tv)) begin
      errors++;
      $display("FAIL ignore_product got %h want %h", r, model(xv, yv, tv));
    end
    checks++;
    if (rc !== t + 64) begin
      errors++;
      $display("FAIL ignore_done_cycle got %0d want %0d", rc, t + 64);
    end
    repeat (5) step();
    checks++;
    if (res_q[0].size() !== 0 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL ignore_single_done extra=%0d busy=%b want 0 0", res_q[0].size(), busy[0]);
    end
  endtask

  task automatic test_back_to_back();
    int t, rc;
    logic [W-1:0] xa, ya, xb, yb;
    logic ta, tb;
    logic [2*W-1:0] ra, rb;
    for (int n = 0; n < 3; n++) begin
      repeat (2) step();
      xa = $urandom; ya = $urandom; ta = 1'($urandom_range(0, 1));
      xb = $urandom; yb = $urandom; tb = 1'($urandom_range(0, 1));
      launch(1, xa, ya, ta);
      t = cyc;
      repeat (64) step();
      checks++;
      if (done[1] !== 1'b1) begin
        errors++;
        $display("FAIL b2b_done_pulse got %b want 1", done[1]);
      end
      launch(1, xb, yb, tb);
      collect(1, ra, rc);
      repeat (64) step();
      checks++;
      if (pv_run[1] !== 128) begin
        errors++;
        $display("FAIL b2b_p_valid_run got %0d want 128", pv_run[1]);
      end
      collect(1, rb, rc);
      checks++;
      if (ra !== model(xa, ya, ta) || rb !== model(xb, yb, tb)) begin
        errors++;
        $display("FAIL b2b_products got %h %h want %h %h", ra, rb, model(xa, ya, ta), model(xb, yb, tb));
      end
      checks++;
      if (rc !== t + 128) begin
        errors++;
        $display("FAIL b2b_done_cycle got %0d want %0d", rc, t + 128);
      end
    end
  endtask

  task automatic test_reset_mid();
    int rc;
    logic [W-1:0] xv, yv;
    logic tv;
    logic [2*W-1:0] r;
    repeat (2) step();
    launch(0, $urandom, $urandom, 1'b1);
    repeat (20) step();
    rst = 1'b1;
    step();
    checks++;
    if ({p, p_valid, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs got %b want 0", {p, p_valid, busy, done});
    end
    rst = 1'b0;
    step();
    xv = $urandom; yv = $urandom; tv = 1'($urandom_range(0, 1));
    launch(0, xv, yv, tv);
    collect(0, r, rc);
    checks++;
    if (r !== model(xv, yv, tv)) begin
      errors++;
      $display("FAIL reset_mid_product got %h want %h", r, model(xv, yv, tv));
    end
    checks++;
    if (res_q[0].size() !== 0) begin
      errors++;
      $display("FAIL reset_mid_stray got %0d results want 0", res_q[0].size());
    end
  endtask

  task automatic test_random();
    int rc0, rc1;
    logic [W-1:0] x0, y0, x1, y1;
    logic t0, t1;
    logic [2*W-1:0] r0, r1;
    for (int n = 0; n < 6; n++) begin
      x0 = $urandom; y0 = $urandom; t0 = 1'($urandom_range(0, 1));
      x1 = $urandom; y1 = $urandom; t1 = 1'($urandom_range(0, 1));
      launch(0, x0, y0, t0);
      repeat ($urandom_range(0, 40)) step();
      launch(1, x1, y1, t1);
      collect(0, r0, rc0);
      collect(1, r1, rc1);
      checks++;
      if (r0 !== model(x0, y0, t0) || r1 !== model(x1, y1, t1)) begin
        errors++;
        $display("FAIL random_%0d got %h %h want %h %h", n, r0, r1, model(x0, y0, t0), model(x1, y1, t1));
      end
      repeat ($urandom_range(1, 3)) step();
    end
  endtask

  task automatic test_protocol();
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL protocol_violations got %0d want 0", bad);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = '0;
    tc = '0;
    x = '0;
    y = '0;
    for (int l = 0; l < CH; l++) begin
      ysrc[l] = '0;
      ypos[l] = W;
      nbits[l] = 0;
      pv_run[l] = 0;
      bits[l] = '0;
    end
    test_reset();
    test_basic();
    test_ones();
    test_two_lanes();
    test_ignore();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_protocol();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
